// File: rtl/ext_pkg.sv
// Shared definitions for the load/immediate extension unit: op codes, FSM states
// and the legality check applied when an operation is accepted.
package ext_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_LW    = 3'd0;
    localparam logic [OP_W-1:0] OP_LH    = 3'd1;
    localparam logic [OP_W-1:0] OP_LHU   = 3'd2;
    localparam logic [OP_W-1:0] OP_LB    = 3'd3;
    localparam logic [OP_W-1:0] OP_LBU   = 3'd4;
    localparam logic [OP_W-1:0] OP_IMM_S = 3'd5;
    localparam logic [OP_W-1:0] OP_IMM_Z = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Misaligned word/half loads and the unused op code complete at once with a fault.
    function automatic logic op_faults(input logic [OP_W-1:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LW:                             return addr_lo != 2'b00;
            OP_LH, OP_LHU:                     return addr_lo[0];
            OP_LB, OP_LBU, OP_IMM_S, OP_IMM_Z: return 1'b0;
            default:                           return 1'b1;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [OP_W-1:0] op);
        return (op == OP_IMM_S) || (op == OP_IMM_Z);
    endfunction

endpackage

// File: rtl/load_imm_extend_unit_if.sv
// Request/memory/result bundle of the load/immediate extension unit.
interface load_imm_extend_unit_if #(
    parameter int IMM_W = 16
);
    logic              start;
    logic [2:0]        op;
    logic [1:0]        addr_lo;
    logic [IMM_W-1:0]  imm;
    logic [31:0]       mem_data;
    logic              mem_rd;
    logic              busy;
    logic              done;
    logic [31:0]       result;
    logic              fault;

    modport master (
        output start, op, addr_lo, imm, mem_data,
        input  mem_rd, busy, done, result, fault
    );

    modport slave (
        input  start, op, addr_lo, imm, mem_data,
        output mem_rd, busy, done, result, fault
    );
endinterface

// File: rtl/lane_extract.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module lane_extract
    import ext_pkg::*;
(
    input  logic [31:0]     i_mem_data,
    input  logic [1:0]      i_addr_lo,
    input  logic [OP_W-1:0] i_op,
    output logic [31:0]     o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_byte = i_mem_data[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        o_ext  = '0;
        case (i_op)
            OP_LW:   o_ext = i_mem_data;
            OP_LH:   o_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ext = {16'h0000, w_half};
            OP_LB:   o_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ext = {24'h000000, w_byte};
            default: o_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_imm_extend_unit.sv
// Immediate extension (1 cycle) and memory load sequencing (MEM_WAIT+2 cycles)
// with registered result, done pulse and fault flag.
module load_imm_extend_unit
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    load_imm_extend_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    state_e          r_state,   w_state_nx;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [OP_W-1:0] r_op,      w_op_nx;
    logic [1:0]      r_addr_lo, w_addr_lo_nx;
    logic            r_mem_rd,  w_mem_rd_nx;
    logic [31:0]     r_result,  w_result_nx;
    logic            r_fault,   w_fault_nx;
    logic            r_busy;
    logic            r_done;
    logic [31:0]     w_lane;
    logic [31:0]     w_imm_ext;

    lane_extract u_lane_extract (
        .i_mem_data (bus.mem_data),
        .i_addr_lo  (r_addr_lo),
        .i_op       (r_op),
        .o_ext      (w_lane)
    );

    assign w_imm_ext = (bus.op == OP_IMM_S) ? {{(32-IMM_W){bus.imm[IMM_W-1]}}, bus.imm}
                                            : {{(32-IMM_W){1'b0}}, bus.imm};

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_op_nx      = r_op;
        w_addr_lo_nx = r_addr_lo;
        w_mem_rd_nx  = 1'b0;
        w_result_nx  = r_result;
        w_fault_nx   = r_fault;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op_nx      = bus.op;
                    w_addr_lo_nx = bus.addr_lo;
                    if (op_faults(bus.op, bus.addr_lo)) begin
                        w_result_nx = '0;
                        w_fault_nx  = 1'b1;
                        w_state_nx  = ST_DONE;
                    end else if (is_imm_op(bus.op)) begin
                        w_result_nx = w_imm_ext;
                        w_fault_nx  = 1'b0;
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_cnt_nx    = CNT_W'(MEM_WAIT);
                        w_mem_rd_nx = 1'b1;
                        w_state_nx  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else begin
                    w_result_nx = w_lane;
                    w_fault_nx  = 1'b0;
                    w_state_nx  = ST_DONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_addr_lo <= '0;
            r_mem_rd  <= 1'b0;
            r_result  <= '0;
            r_fault   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_op      <= w_op_nx;
            r_addr_lo <= w_addr_lo_nx;
            r_mem_rd  <= w_mem_rd_nx;
            r_result  <= w_result_nx;
            r_fault   <= w_fault_nx;
            r_busy    <= (w_state_nx != ST_IDLE);
            r_done    <= (w_state_nx == ST_DONE);
        end
    end

    assign bus.mem_rd = r_mem_rd;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.fault  = r_fault;

endmodule

// File: tb/tb_load_imm_extend_unit.sv
// Bench for load_imm_extend_unit: two instances (MEM_WAIT=1 and 3) checked against
// an arithmetic reference model of the extension and latency rules.
module tb_load_imm_extend_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  start_v;
    logic [2:0]  op;
    logic [1:0]  addr_lo;
    logic [15:0] imm;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_imm_extend_unit_if #(.IMM_W(16)) bus1 ();
    load_imm_extend_unit_if #(.IMM_W(16)) bus3 ();

    assign bus1.start    = start_v[0];
    assign bus1.op       = op;
    assign bus1.addr_lo  = addr_lo;
    assign bus1.imm      = imm;
    assign bus1.mem_data = mem_data;
    assign bus3.start    = start_v[1];
    assign bus3.op       = op;
    assign bus3.addr_lo  = addr_lo;
    assign bus3.imm      = imm;
    assign bus3.mem_data = mem_data;

    load_imm_extend_unit #(.IMM_W(16), .MEM_WAIT(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    load_imm_extend_unit #(.IMM_W(16), .MEM_WAIT(3)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    logic [1:0]  mon_rd, mon_busy, mon_done, mon_fault;
    logic [31:0] mon_res0, mon_res1;
    assign mon_rd    = {bus3.mem_rd, bus1.mem_rd};
    assign mon_busy  = {bus3.busy,   bus1.busy};
    assign mon_done  = {bus3.done,   bus1.done};
    assign mon_fault = {bus3.fault,  bus1.fault};
    assign mon_res0  = bus1.result;
    assign mon_res1  = bus3.result;

    function automatic logic [31:0] res_of(input int sel);
        return (sel != 0) ? mon_res1 : mon_res0;
    endfunction

    // Reference: {fault, result}; sign extension done by adding the high-ones pattern.
    function automatic logic [32:0] model(input logic [2:0] o, input logic [1:0] a,
                                          input logic [15:0] im, input logic [31:0] md);
        logic [31:0] b, h, r;
        logic        f;
        b = (md >> (8 * a)) & 32'hFF;
        h = (md >> (16 * (a / 2))) & 32'hFFFF;
        r = 32'h0;
        f = 1'b0;
        case (o)
            3'd0: if (a != 0) f = 1'b1; else r = md;
            3'd1: if (a % 2 != 0) f = 1'b1; else r = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2: if (a % 2 != 0) f = 1'b1; else r = h;
            3'd3: r = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4: r = b;
            3'd5: r = (im >= 16'd32768) ? {16'h0000, im} + 32'hFFFF0000 : {16'h0000, im};
            3'd6: r = {16'h0000, im};
            default: f = 1'b1;
        endcase
        return {f, f ? 32'h0 : r};
    endfunction

    task automatic run_op(input int sel, input logic [2:0] o, input logic [1:0] a,
                          input logic [15:0] im, input logic [31:0] md, input string name);
        logic [32:0] exp_v;
        bit          mem_op;
        bit          got;
        int          exp_lat, cyc, rd_cnt, rd_first;
        exp_v   = model(o, a, im, md);
        mem_op  = !exp_v[32] && (o <= 3'd4);
        exp_lat = mem_op ? ((sel != 0) ? 3 : 1) + 2 : 1;
        @(negedge clk);
        op = o; addr_lo = a; imm = im; mem_data = md;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        op = 3'($urandom); addr_lo = 2'($urandom); imm = 16'($urandom);
        cyc = 1; rd_cnt = 0; rd_first = 0; got = 0;
        n_checks++;
        if (mon_busy[sel] !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, mon_busy[sel]);
        end
        while (!got && cyc <= 12) begin
            if (mon_rd[sel] === 1'b1) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = cyc;
            end
            if (mon_done[sel] === 1'b1) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s timeout: no done within 12 cycles, expected at cycle %0d", name, exp_lat);
        end else begin
            n_checks += 4;
            if (cyc != exp_lat) begin
                n_errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
            end
            if (res_of(sel) !== exp_v[31:0]) begin
                n_errors++;
                $display("FAIL %s result: got %h expected %h", name, res_of(sel), exp_v[31:0]);
            end
            if (mon_fault[sel] !== exp_v[32]) begin
                n_errors++;
                $display("FAIL %s fault: got %b expected %b", name, mon_fault[sel], exp_v[32]);
            end
            if (rd_cnt != (mem_op ? 1 : 0) || (mem_op && rd_first != 1)) begin
                n_errors++;
                $display("FAIL %s mem_rd: got %0d pulses first at %0d expected %0d at 1",
                         name, rd_cnt, rd_first, mem_op ? 1 : 0);
            end
        end
        @(posedge clk); #1;
        n_checks += 2;
        if (mon_done[sel] !== 1'b0 || mon_busy[sel] !== 1'b0) begin
            n_errors++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0 0",
                     name, mon_done[sel], mon_busy[sel]);
        end
        if (res_of(sel) !== exp_v[31:0] || mon_fault[sel] !== exp_v[32]) begin
            n_errors++;
            $display("FAIL %s hold: got %h/%b expected %h/%b", name, res_of(sel),
                     mon_fault[sel], exp_v[31:0], exp_v[32]);
        end
    endtask

    task automatic expect_idle_zero(input int sel, input string name);
        n_checks++;
        if ({mon_rd[sel], mon_busy[sel], mon_done[sel], mon_fault[sel]} !== 4'b0000
            || res_of(sel) !== 32'h0) begin
            n_errors++;
            $display("FAIL %s: got rd=%b busy=%b done=%b fault=%b result=%h expected all 0",
                     name, mon_rd[sel], mon_busy[sel], mon_done[sel], mon_fault[sel], res_of(sel));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_v = 2'b11;
        op = 3'd0; addr_lo = 2'd0; imm = 16'h1234; mem_data = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            expect_idle_zero(0, "reset_mw1");
            expect_idle_zero(1, "reset_mw3");
        end
        @(negedge clk);
        start_v = 2'b00;
        reset_n = 1'b1;
    endtask

    task automatic test_imm();
        run_op(0, 3'd5, 2'd0, 16'h8001, 32'h0, "imm_s");
        run_op(0, 3'd6, 2'd0, 16'h8001, 32'h0, "imm_z");
        run_op(1, 3'd5, 2'd3, 16'h7FFF, 32'h0, "imm_s_pos");
    endtask

    task automatic test_loads();
        run_op(0, 3'd3, 2'd3, 16'h0, 32'h80FF7F01, "lb_3");
        run_op(0, 3'd4, 2'd1, 16'h0, 32'h80FF7F01, "lbu_1");
        run_op(0, 3'd1, 2'd2, 16'h0, 32'h80FF7F01, "lh_2");
        run_op(0, 3'd2, 2'd0, 16'h0, 32'h80FF7F01, "lhu_0");
        run_op(0, 3'd0, 2'd0, 16'h0, 32'h80FF7F01, "lw_0");
        run_op(1, 3'd3, 2'd2, 16'h0, 32'h80FF7F01, "lb_2_mw3");
    endtask

    task automatic test_faults();
        run_op(0, 3'd1, 2'd1, 16'h0, 32'h80FF7F01, "fault_lh_1");
        run_op(0, 3'd0, 2'd2, 16'h0, 32'h80FF7F01, "fault_lw_2");
        run_op(0, 3'd7, 2'd0, 16'h0, 32'h80FF7F01, "fault_op7");
        run_op(1, 3'd2, 2'd3, 16'h0, 32'h80FF7F01, "fault_lhu_3_mw3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom),
                   16'($urandom), $urandom, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_busy_ignore();
        int dones, first_cyc;
        logic [31:0] first_res;
        @(negedge clk);
        op = 3'd0; addr_lo = 2'd0; mem_data = 32'h13579BDF; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        dones = 0; first_cyc = 0; first_res = 32'h0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 2) begin
                op = 3'd3; addr_lo = 2'd3; start_v[1] = 1'b1;
            end else if (cyc == 3) begin
                start_v[1] = 1'b0;
            end
            if (mon_done[1] === 1'b1) begin
                dones++;
                if (first_cyc == 0) begin
                    first_cyc = cyc;
                    first_res = mon_res1;
                end
            end
            @(posedge clk); #1;
        end
        n_checks += 2;
        if (dones != 1 || first_cyc != 5) begin
            n_errors++;
            $display("FAIL busy_ignore_done: got %0d dones first at %0d expected 1 at 5", dones, first_cyc);
        end
        if (first_res !== 32'h13579BDF) begin
            n_errors++;
            $display("FAIL busy_ignore_result: got %h expected 13579bdf", first_res);
        end
    endtask

    task automatic test_reset_midflight();
        int dones;
        @(negedge clk);
        op = 3'd0; addr_lo = 2'd0; mem_data = 32'hA5A50001; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        expect_idle_zero(1, "midflight_reset");
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mon_done[1] === 1'b1 || mon_rd[1] === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++;
            $display("FAIL midflight_no_done: got %0d done/rd cycles expected 0", dones);
        end
        run_op(1, 3'd0, 2'd0, 16'h0, 32'hCAFEF00D, "lw_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_imm();
        test_loads();
        test_faults();
        test_random();
        test_busy_ignore();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
